lsu_mem_if: RTL and testbench

//  Load/store unit between ctrl_datapath and the data bus (DAD/DDT side). Consumes alu_out (address)
//  and rd2 (store data); drives a request/ack bus, formats byte/half/word stores, and returns

---
 rtl/lsu_mem_if.sv | 85 ++++++++
 tb/tb_lsu_mem_if.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit with request/ack data bus, store lane replication and load extension
module lsu_mem_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        bus_err,
  output logic [31:0] DAD,
  output logic [31:0] DDT_out,
  input  logic [31:0] DDT_in,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  input  logic        ACK
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_inc;
  logic sign;
  logic [1:0] lane;
  logic access, illegal, start, timeout;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext, lanes;
  assign access = mem_read | mem_write;
  assign illegal = (funct3[1:0] == 2'b11) | (funct3[2] & funct3[1]) | (mem_write & funct3[2])
                 | (funct3[1:0] == 2'b01 & addr[0]) | (funct3[1:0] == 2'b10 & addr[1:0] != 2'b00);
  // the cycle after a fault the same instruction is still presented; it must not be re-evaluated
  assign start = (state == IDLE) & access & ~fault;
  assign cnt_inc = cnt + 8'd1;
  assign timeout = ~ACK & (cnt_inc == 8'(TIMEOUT));
  assign byte_sel = DDT_in[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? DDT_in[31:16] : DDT_in[15:0];
  assign ext = SIZE == 2'b00 ? {{24{sign & byte_sel[7]}}, byte_sel}
             : SIZE == 2'b01 ? {{16{sign & half_sel[15]}}, half_sel} : DDT_in;
  assign lanes = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}}
               : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (start & ~illegal ? REQ : IDLE)
            : state == REQ ? (ACK | timeout ? DONE : REQ) : IDLE;
  end
  always_comb begin
    stall = (state == REQ) | start;
    MREQ = state == REQ;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      fault <= 1'b0;
      bus_err <= 1'b0;
      load_data <= '0;
      DAD <= '0;
      DDT_out <= '0;
      WRITE <= 1'b0;
      SIZE <= 2'b00;
      sign <= 1'b0;
      lane <= 2'b00;
    end else begin
      fault <= start & illegal;
      bus_err <= (state == REQ) & timeout;
      cnt <= (state == REQ) & ~ACK & ~timeout ? cnt_inc : 8'd0;
      if (start & ~illegal) begin
        DAD <= addr;
        DDT_out <= lanes;
        WRITE <= mem_write;
        SIZE <= funct3[1:0];
        sign <= ~funct3[2];
        lane <= addr[1:0];
      end
      if (state == REQ & ACK & ~WRITE) load_data <= ext;
      else if (state == REQ & timeout) load_data <= '0;
    end
  end
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed checks of load/store handshake, extension, faults, timeout and reset abort
module tb_lsu_mem_if;
  logic clk = 0, rst = 0, mem_read = 0, mem_write = 0, ACK = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, DDT_in = 0;
  logic stall, fault, bus_err, MREQ, WRITE;
  logic [1:0] SIZE;
  logic [31:0] load_data, DAD, DDT_out;
  int vectors = 0, errs = 0, n;
  lsu_mem_if #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data), .fault(fault),
    .bus_err(bus_err), .DAD(DAD), .DDT_out(DDT_out), .DDT_in(DDT_in), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .ACK(ACK)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] din, input logic [31:0] exp);
    mem_read = 1; funct3 = f3; addr = a; DDT_in = din; ACK = 1;
    #1 chk({tag, "_idle_stall"}, stall, 1);
    tick();
    chk({tag, "_mreq"}, MREQ, 1);
    chk({tag, "_req_stall"}, stall, 1);
    tick();
    chk({tag, "_data"}, load_data, exp);
    chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_done_mreq"}, MREQ, 0);
    mem_read = 0; ACK = 0;
    tick();
  endtask
  initial begin
    tick(); tick();
    chk("rst_mreq", MREQ, 0);
    chk("rst_stall", stall, 0);
    chk("rst_load", load_data, 0);
    chk("rst_dad", DAD, 0);
    chk("rst_fault", fault, 0);
    rst = 1;
    tick();
    mem_read = 1; funct3 = 3'b010; addr = 32'h100; DDT_in = 32'hDEADBEEF; ACK = 1;
    #1 chk("lw_stall0", stall, 1);
    chk("lw_mreq0", MREQ, 0);
    tick();
    chk("lw_mreq1", MREQ, 1);
    chk("lw_dad", DAD, 32'h100);
    chk("lw_size", SIZE, 2'b10);
    chk("lw_write", WRITE, 0);
    tick();
    chk("lw_mreq2", MREQ, 0);
    chk("lw_stall2", stall, 0);
    chk("lw_data", load_data, 32'hDEADBEEF);
    mem_read = 0; ACK = 0;
    tick();
    chk("lw_idle_stall", stall, 0);
    load("lb", 3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80);
    load("lbu", 3'b100, 32'h103, 32'h80112233, 32'h00000080);
    load("lhu", 3'b101, 32'h102, 32'h80112233, 32'h00008011);
    load("lh_lo", 3'b001, 32'h100, 32'h80112233, 32'h00002233);
    load("lb1", 3'b000, 32'h101, 32'h80112233, 32'h00000022);
    load("lh_hi", 3'b001, 32'h102, 32'h80112233, 32'hFFFF8011);
    n = 0;
    mem_write = 1; funct3 = 3'b000; addr = 32'h201; wdata = 32'h123456AB; DDT_in = 0;
    #1 if (stall) n++;
    tick();
    chk("sb_ddt", DDT_out, 32'hABABABAB);
    chk("sb_size", SIZE, 2'b00);
    chk("sb_write", WRITE, 1);
    chk("sb_dad", DAD, 32'h201);
    for (int i = 0; i < 3; i++) begin
      if (stall) n++;
      chk("sb_wait_mreq", MREQ, 1);
      tick();
    end
    ACK = 1;
    #1 if (stall) n++;
    tick();
    chk("sb_stall_cycles", n, 5);
    chk("sb_done_stall", stall, 0);
    chk("sb_load_kept", load_data, 32'hFFFF8011);
    mem_write = 0; ACK = 0;
    tick();
    mem_read = 1; funct3 = 3'b010; addr = 32'h102;
    #1 chk("mis_stall0", stall, 1);
    tick();
    chk("mis_fault", fault, 1);
    chk("mis_stall", stall, 0);
    chk("mis_mreq", MREQ, 0);
    mem_read = 0;
    tick();
    chk("mis_fault_clr", fault, 0);
    chk("mis_mreq2", MREQ, 0);
    mem_read = 1; funct3 = 3'b011; addr = 32'h100;
    tick();
    chk("f011_fault", fault, 1);
    chk("f011_stall", stall, 0);
    chk("f011_mreq", MREQ, 0);
    mem_read = 0;
    tick();
    chk("f011_fault_clr", fault, 0);
    mem_write = 1; funct3 = 3'b100; addr = 32'h100;
    tick();
    chk("sbu_fault", fault, 1);
    chk("sbu_mreq", MREQ, 0);
    mem_write = 0;
    tick();
    mem_read = 1; funct3 = 3'b010; addr = 32'h100;
    tick();
    chk("rstmid_mreq", MREQ, 1);
    rst = 0;
    tick();
    chk("rstmid_mreq_off", MREQ, 0);
    chk("rstmid_load", load_data, 0);
    rst = 1; mem_read = 0; ACK = 1; DDT_in = 32'h55555555;
    tick();
    chk("rstmid_ack_ign", MREQ, 0);
    chk("rstmid_load2", load_data, 0);
    chk("rstmid_stall", stall, 0);
    ACK = 0;
    tick();
    load("after_rst", 3'b100, 32'h103, 32'h80112233, 32'h00000080);
    mem_read = 1; funct3 = 3'b010; addr = 32'h300; ACK = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (MREQ) n++;
    end
    chk("to_mreq_cycles", n, 4);
    chk("to_bus_err", bus_err, 1);
    chk("to_fault", fault, 0);
    chk("to_load", load_data, 0);
    chk("to_stall", stall, 0);
    mem_read = 0;
    tick();
    chk("to_bus_err_clr", bus_err, 0);
    chk("to_idle_mreq", MREQ, 0);
    load("after_to", 3'b010, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
